wb_shared_mem_arbiter: RTL and testbench

- Two-master to one-slave Wishbone classic arbiter that shares a single memory port between the core instruction-fetch master (m0) and the data master (m1).
- Used when the platform exposes only one core memory bus, i.e. the second data-memory port is absent.
- Sits between the processor core and the Controller's core bus.
- Provides round-robin grant, burst lock on cyc, an optional registered response path and a bus watchdog.

---
 rtl/wb_shared_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_shared_mem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_shared_mem_arbiter.sv
// Two-master to one-slave Wishbone classic arbiter: round-robin grant, cyc burst
// lock, optional registered response path and a stalled-slave watchdog.
module wb_shared_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int REG_RESPONSE   = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  output logic                    timeout_o
);

  localparam int SW  = DATA_WIDTH / 8;
  localparam int CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT_CYCLES);
  localparam bit WD_EN  = (TIMEOUT_CYCLES != 0);
  localparam bit REG_EN = (REG_RESPONSE != 0);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, TERM} state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;

  logic own0, own1, own, own_cyc, own_stb;
  logic req0, req1, ack_pending, expiry, resp_ack;
  logic [DATA_WIDTH-1:0] resp_dat;

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);
  assign own  = own0 | own1;
  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  assign own_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
  assign own_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);

  // While a registered ack is in flight toward the master, hide stb so the
  // slave does not see the same access twice.
  assign ack_pending = REG_EN & ack_q;

  assign s_cyc_o = own_cyc;
  assign s_stb_o = own & own_stb & ~ack_pending;
  assign s_we_o  = (own0 & m0_we_i) | (own1 & m1_we_i);
  assign s_sel_o = own0 ? m0_sel_i : (own1 ? m1_sel_i : '0);
  assign s_adr_o = own0 ? m0_adr_i : (own1 ? m1_adr_i : '0);
  assign s_dat_o = own0 ? m0_dat_i : (own1 ? m1_dat_i : '0);

  // A same-cycle slave ack always beats watchdog expiry.
  assign expiry    = WD_EN & own & own_cyc & (cnt_q == TO_CNT) & ~s_ack_i;
  assign timeout_o = expiry;

  assign resp_ack = REG_EN ? ack_q : s_ack_i;
  assign resp_dat = REG_EN ? dat_q : s_dat_i;

  assign m0_ack_o = own0 & resp_ack;
  assign m1_ack_o = own1 & resp_ack;
  assign m0_err_o = own0 & expiry;
  assign m1_err_o = own1 & expiry;
  assign m0_dat_o = own0 ? resp_dat : '0;
  assign m1_dat_o = own1 ? resp_dat : '0;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d      = last_grant_q ? OWN0 : OWN1;
          last_grant_d = ~last_grant_q;
        end else if (req0) begin
          state_d      = OWN0;
          last_grant_d = 1'b0;
        end else if (req1) begin
          state_d      = OWN1;
          last_grant_d = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (expiry)        state_d = TERM;
        else if (!own_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog counts stalled strobe cycles and saturates at the limit.
  always_comb begin
    cnt_d = '0;
    if (WD_EN && own) begin
      if (s_ack_i)                         cnt_d = '0;
      else if (s_stb_o && cnt_q != TO_CNT) cnt_d = cnt_q + CW'(1);
      else                                 cnt_d = cnt_q;
    end
  end

  always_comb begin
    ack_d = REG_EN & own & s_stb_o & s_ack_i;
    dat_d = ack_d ? s_dat_i : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      ack_q        <= 1'b0;
      dat_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      dat_q        <= dat_d;
    end
  end

  logic unused_sw;
  assign unused_sw = (SW == 0);

endmodule

// File: tb/tb_wb_shared_mem_arbiter.sv
// Directed bench for wb_shared_mem_arbiter: combinational-response instance plus
// a registered-response instance sharing the same stimulus.
module tb_wb_shared_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [3:0]  s_sel_o;

  logic [31:0] r_m0_dat_o, r_m1_dat_o, r_s_adr_o, r_s_dat_o;
  logic        r_m0_ack_o, r_m0_err_o, r_m1_ack_o, r_m1_err_o;
  logic        r_s_cyc_o, r_s_stb_o, r_s_we_o, r_timeout_o;
  logic [3:0]  r_s_sel_o;

  int total = 0;
  int bad   = 0;
  int r_acks = 0;
  int a0;

  always #5 clk = ~clk;

  wb_shared_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .REG_RESPONSE(0)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .timeout_o(timeout_o)
  );

  wb_shared_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .REG_RESPONSE(1)) dut_r (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(r_m0_dat_o), .m0_ack_o(r_m0_ack_o), .m0_err_o(r_m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(r_m1_dat_o), .m1_ack_o(r_m1_ack_o), .m1_err_o(r_m1_err_o),
    .s_cyc_o(r_s_cyc_o), .s_stb_o(r_s_stb_o), .s_we_o(r_s_we_o), .s_sel_o(r_s_sel_o), .s_adr_o(r_s_adr_o),
    .s_dat_o(r_s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .timeout_o(r_timeout_o)
  );

  // Accesses the registered-response slave actually accepted.
  always @(posedge clk) if (r_s_cyc_o && r_s_stb_o && s_ack_i) r_acks <= r_acks + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctrl();
    return 32'({s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, timeout_o});
  endfunction

  task automatic nc();
    @(posedge clk); #1;
  endtask

  task automatic drv0(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    m0_cyc_i = c; m0_stb_i = c; m0_we_i = w; m0_adr_i = a; m0_dat_i = d;
  endtask

  task automatic drv1(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    m1_cyc_i = c; m1_stb_i = c; m1_we_i = w; m1_adr_i = a; m1_dat_i = d;
  endtask

  task automatic slv(input logic ack, input logic [31:0] d);
    s_ack_i = ack; s_dat_i = d;
  endtask

  initial begin
    rst = 1'b1;
    drv0(0, 0, 0, 0); drv1(0, 0, 0, 0); slv(0, 0);
    m0_sel_i = 4'hF; m1_sel_i = 4'hF;
    nc(); nc(); #1;
    chk("reset_ctrl", ctrl(), 32'h0);
    chk("reset_adr", s_adr_o, 32'h0);
    chk("reset_m1_dat", m1_dat_o, 32'h0);

    // Single master read with two wait states
    nc(); rst = 1'b0; drv1(1, 0, 32'h100, 0); #1;
    chk("t1_no_grant_yet", 32'(s_cyc_o), 32'h0);
    nc(); #1;
    chk("t1_grant_cyc", 32'({s_cyc_o, s_stb_o}), 32'h3);
    chk("t1_adr", s_adr_o, 32'h100);
    nc(); #1;
    chk("t1_wait_no_ack", 32'(m1_ack_o), 32'h0);
    nc(); slv(1, 32'hDEADBEEF); #1;
    chk("t1_m1_ack", 32'(m1_ack_o), 32'h1);
    chk("t1_m1_dat", m1_dat_o, 32'hDEADBEEF);
    chk("t1_m0_quiet", 32'({m0_ack_o, m0_err_o}), 32'h0);
    chk("t1_m0_dat", m0_dat_o, 32'h0);
    nc(); drv1(0, 0, 0, 0); slv(0, 0); #1;
    chk("t1_release", 32'(s_cyc_o), 32'h0);

    // Tie after reset: m0 first, then alternate
    nc(); rst = 1'b1;
    nc(); rst = 1'b0; drv0(1, 0, 32'h10, 0); drv1(1, 0, 32'h20, 0); #1;
    chk("t2_idle", 32'(s_cyc_o), 32'h0);
    nc(); slv(1, 32'h11); #1;
    chk("t2_g0_adr", s_adr_o, 32'h10);
    chk("t2_g0_ack", 32'({m0_ack_o, m1_ack_o}), 32'h2);
    nc(); drv0(0, 0, 0, 0); slv(0, 0); #1;
    chk("t2_drop0", 32'(s_cyc_o), 32'h0);
    nc(); drv0(1, 0, 32'h10, 0); #1;
    chk("t2_idle1", 32'(s_cyc_o), 32'h0);
    nc(); slv(1, 32'h22); #1;
    chk("t2_g1_adr", s_adr_o, 32'h20);
    chk("t2_g1_ack", 32'({m0_ack_o, m1_ack_o}), 32'h1);
    nc(); drv1(0, 0, 0, 0); slv(0, 0); #1;
    nc(); drv1(1, 0, 32'h20, 0); #1;
    chk("t2_idle2", 32'(s_cyc_o), 32'h0);
    nc(); slv(1, 0); #1;
    chk("t2_g2_adr", s_adr_o, 32'h10);
    nc(); drv0(0, 0, 0, 0); slv(0, 0); #1;
    nc(); drv0(1, 0, 32'h10, 0); #1;
    nc(); slv(1, 0); #1;
    chk("t2_g3_adr", s_adr_o, 32'h20);
    nc(); drv0(0, 0, 0, 0); drv1(0, 0, 0, 0); slv(0, 0); #1;
    nc(); #1;

    // Burst lock: m0 holds cyc for four acked accesses while m1 waits
    nc(); drv0(1, 0, 32'h0, 0); drv1(1, 1, 32'h40, 32'hAA); #1;
    chk("t3_idle", 32'(s_cyc_o), 32'h0);
    for (int k = 0; k < 4; k++) begin
      nc(); drv0(1, 0, 32'(4 * k), 0); slv(1, 0); #1;
      chk($sformatf("t3_adr%0d", k), s_adr_o, 32'(4 * k));
      chk($sformatf("t3_acks%0d", k), 32'({m0_ack_o, m1_ack_o}), 32'h2);
    end
    nc(); drv0(0, 0, 0, 0); slv(0, 0); #1;
    chk("t3_drop", 32'({s_cyc_o, m1_ack_o}), 32'h0);
    nc(); #1;
    chk("t3_dead", 32'(s_cyc_o), 32'h0);
    nc(); slv(1, 0); #1;
    chk("t3_m1_grant", 32'({s_cyc_o, s_we_o, m1_ack_o}), 32'h7);
    chk("t3_m1_adr", s_adr_o, 32'h40);
    nc(); drv1(0, 0, 0, 0); slv(0, 0); #1;

    // Watchdog: slave never acks m1's write
    nc(); drv1(1, 1, 32'h200, 32'h12345678); #1;
    chk("t4_idle", 32'(s_cyc_o), 32'h0);
    nc(); drv0(1, 0, 32'h500, 0); #1;
    chk("t4_first_stb", 32'({s_cyc_o, s_stb_o, s_we_o}), 32'h7);
    chk("t4_wdat", s_dat_o, 32'h12345678);
    for (int i = 2; i <= 8; i++) begin
      nc(); #1;
      chk($sformatf("t4_wait%0d", i), 32'({m1_err_o, timeout_o}), 32'h0);
    end
    nc(); #1;
    chk("t4_expiry", 32'({m1_ack_o, m1_err_o, timeout_o, m0_err_o}), 32'h6);
    nc(); drv1(0, 0, 0, 0); #1;
    chk("t4_term", 32'({s_cyc_o, m1_err_o, timeout_o}), 32'h0);
    nc(); #1;
    chk("t4_idle_after", 32'(s_cyc_o), 32'h0);
    nc(); slv(1, 0); #1;
    chk("t4_m0_grant", 32'({s_cyc_o, m0_ack_o}), 32'h3);
    chk("t4_m0_adr", s_adr_o, 32'h500);
    nc(); drv0(0, 0, 0, 0); slv(0, 0); #1;

    // Registered response instance
    nc(); rst = 1'b1;
    nc(); rst = 1'b0; drv0(1, 0, 32'h300, 0); a0 = r_acks; #1;
    chk("t5_idle", 32'(r_s_cyc_o), 32'h0);
    nc(); #1;
    chk("t5_grant", 32'({r_s_cyc_o, r_s_stb_o}), 32'h3);
    nc(); slv(1, 32'hCAFEF00D); #1;
    chk("t5_ack_cycle", 32'({r_m0_ack_o, r_s_stb_o}), 32'h1);
    nc(); slv(1, 32'h0); #1;
    chk("t5_reg_ack", 32'({r_m0_ack_o, r_s_stb_o, r_s_cyc_o}), 32'h5);
    chk("t5_reg_dat", r_m0_dat_o, 32'hCAFEF00D);
    nc(); drv0(0, 0, 0, 0); slv(0, 0); #1;
    chk("t5_no_dup_ack", 32'(r_m0_ack_o), 32'h0);
    chk("t5_slave_acks", 32'(r_acks - a0), 32'h1);

    // Reset during an OWN1 wait state
    nc(); drv1(1, 0, 32'h400, 0); #1;
    nc(); rst = 1'b1; #1;
    chk("t6_own1", 32'(s_cyc_o), 32'h1);
    nc(); rst = 1'b0; drv0(1, 0, 32'h600, 0); slv(1, 32'h55); #1;
    chk("t6_post_reset_ctrl", ctrl(), 32'h0);
    chk("t6_post_reset_dat", m1_dat_o, 32'h0);
    chk("t6_post_reset_adr", s_adr_o, 32'h0);
    nc(); #1;
    chk("t6_m0_first", s_adr_o, 32'h600);
    chk("t6_m0_ack", 32'({s_cyc_o, m0_ack_o, m1_ack_o}), 32'h6);
    nc(); drv0(0, 0, 0, 0); drv1(0, 0, 0, 0); slv(0, 0); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
